// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register for the 5-stage MIPS pipeline.
// It latches the decoded operands and control bits and forwards ALU operands
// from EX/MEM and MEM/WB. It also flags load-use hazards and computes the
// branch target.
// Optional feature macro: ID_EX_FWD_EN
//   - defined:   EX/MEM and MEM/WB forwarding muxes are built.
//   - undefined: operands come straight from the register file, and
//                load_use_stall also interlocks on any EX-stage register writer.

`ifdef ID_EX_FWD_EN
// Per-operand forwarding select. EX/MEM is the younger result, so it wins.
// Register 0 is hard-wired to zero and is never forwarded.
module id_ex_fwd #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] src,
    input  logic [DATA_W-1:0] rf_data,
    input  logic              exmem_reg_write,
    input  logic [REG_AW-1:0] exmem_rd,
    input  logic [DATA_W-1:0] exmem_alu_result,
    input  logic              memwb_reg_write,
    input  logic [REG_AW-1:0] memwb_rd,
    input  logic [DATA_W-1:0] memwb_wdata,
    output logic [DATA_W-1:0] data
);
    // priority mux: EX/MEM over MEM/WB over register file
    always_comb begin
        data = rf_data;
        if (memwb_reg_write && (memwb_rd != '0) && (memwb_rd == src))
            data = memwb_wdata;
        if (exmem_reg_write && (exmem_rd != '0) && (exmem_rd == src))
            data = exmem_alu_result;
    end
endmodule
`endif

module id_ex_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              flush,
    input  logic              id_valid,
    input  logic [DATA_W-1:0] id_rs_data,
    input  logic [DATA_W-1:0] id_rt_data,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [DATA_W-1:0] id_pc_plus4,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_alu_src,
    input  logic              id_reg_dst,
    input  logic [2:0]        id_alu_control,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              id_mem_write,
    input  logic              id_branch,
    input  logic              exmem_reg_write,
    input  logic [REG_AW-1:0] exmem_rd,
    input  logic [DATA_W-1:0] exmem_alu_result,
    input  logic              memwb_reg_write,
    input  logic [REG_AW-1:0] memwb_rd,
    input  logic [DATA_W-1:0] memwb_wdata,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [2:0]        alu_control,
    output logic [DATA_W-1:0] ex_store_data,
    output logic [REG_AW-1:0] ex_write_reg,
    output logic [DATA_W-1:0] ex_branch_target,
    output logic              ex_valid,
    output logic              ex_reg_write,
    output logic              ex_mem_read,
    output logic              ex_mem_write,
    output logic              ex_branch,
    output logic              load_use_stall
);
    localparam int NUM_OPND = 2;  // rs, rt

    typedef struct packed {
        logic              valid;
        logic              reg_write;
        logic              mem_read;
        logic              mem_write;
        logic              branch;
        logic              alu_src;
        logic [2:0]        alu_control;
        logic [REG_AW-1:0] rs;
        logic [REG_AW-1:0] rt;
        logic [REG_AW-1:0] write_reg;
        logic [DATA_W-1:0] rs_data;
        logic [DATA_W-1:0] rt_data;
        logic [DATA_W-1:0] imm;
        logic [DATA_W-1:0] branch_target;
    } id_ex_t;

    id_ex_t d, q;

    // next-state bundle from the ID stage; destination and target are resolved here
    always_comb begin
        d               = '0;
        d.valid         = id_valid;
        d.reg_write     = id_reg_write;
        d.mem_read      = id_mem_read;
        d.mem_write     = id_mem_write;
        d.branch        = id_branch;
        d.alu_src       = id_alu_src;
        d.alu_control   = id_alu_control;
        d.rs            = id_rs;
        d.rt            = id_rt;
        d.write_reg     = id_reg_dst ? id_rd : id_rt;
        d.rs_data       = id_rs_data;
        d.rt_data       = id_rt_data;
        d.imm           = id_imm;
        d.branch_target = id_pc_plus4 + (id_imm << 2);
    end

    // pipeline register: flush beats stall; a flush only clears valid/control,
    // and data fields keep stale values because nothing reads them without valid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (flush) begin
            q.valid       <= 1'b0;
            q.reg_write   <= 1'b0;
            q.mem_read    <= 1'b0;
            q.mem_write   <= 1'b0;
            q.branch      <= 1'b0;
            q.alu_src     <= 1'b0;
            q.alu_control <= 3'b000;
        end else if (!stall) begin
            q <= d;
        end
    end

    // operand lanes: index 0 = rs, index 1 = rt
    logic [NUM_OPND-1:0][REG_AW-1:0] opnd_idx;
    logic [NUM_OPND-1:0][DATA_W-1:0] opnd_rf;
    logic [NUM_OPND-1:0][DATA_W-1:0] opnd_fwd;

    assign opnd_idx = {q.rt, q.rs};
    assign opnd_rf  = {q.rt_data, q.rs_data};

`ifdef ID_EX_FWD_EN
    for (genvar i = 0; i < NUM_OPND; i++) begin : g_fwd
        id_ex_fwd #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd (
            .src              (opnd_idx[i]),
            .rf_data          (opnd_rf[i]),
            .exmem_reg_write  (exmem_reg_write),
            .exmem_rd         (exmem_rd),
            .exmem_alu_result (exmem_alu_result),
            .memwb_reg_write  (memwb_reg_write),
            .memwb_rd         (memwb_rd),
            .memwb_wdata      (memwb_wdata),
            .data             (opnd_fwd[i])
        );
    end

    // only a load in EX needs a bubble; ALU results reach EX via forwarding
    logic producer;
    assign producer = q.mem_read;
`else
    assign opnd_fwd = opnd_rf;

    // without forwarding, any EX-stage writer is a hazard for the ID reader
    logic producer;
    assign producer = q.mem_read | q.reg_write;

    // forwarding sources and registered indices have no consumer in this build
    logic unused_fwd;
    assign unused_fwd = ^{exmem_reg_write, exmem_rd, exmem_alu_result,
                          memwb_reg_write, memwb_rd, memwb_wdata, opnd_idx};
`endif

    assign alu_a            = opnd_fwd[0];
    assign alu_b            = q.alu_src ? q.imm : opnd_fwd[1];
    assign ex_store_data    = opnd_fwd[1];
    assign alu_control      = q.alu_control;
    assign ex_write_reg     = q.write_reg;
    assign ex_branch_target = q.branch_target;

    // control outputs are gated by valid so a bubble can never write or branch
    assign ex_valid     = q.valid;
    assign ex_reg_write = q.valid & q.reg_write;
    assign ex_mem_read  = q.valid & q.mem_read;
    assign ex_mem_write = q.valid & q.mem_write;
    assign ex_branch    = q.valid & q.branch;

    assign load_use_stall = q.valid & producer & (q.write_reg != '0) &
                            ((q.write_reg == id_rs) | (q.write_reg == id_rt));
endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage. A reference model computes the expected EX
// state per edge and pushes it to a queue. The record is popped after the
// edge and compared against the outputs. Forwarding expectations follow
// ID_EX_FWD_EN.
module tb_id_ex_stage;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall, flush, id_valid;
    logic [31:0] id_rs_data, id_rt_data, id_imm, id_pc_plus4;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic        id_alu_src, id_reg_dst;
    logic [2:0]  id_alu_control;
    logic        id_reg_write, id_mem_read, id_mem_write, id_branch;
    logic        exmem_reg_write;
    logic [4:0]  exmem_rd;
    logic [31:0] exmem_alu_result;
    logic        memwb_reg_write;
    logic [4:0]  memwb_rd;
    logic [31:0] memwb_wdata;
    logic [31:0] alu_a, alu_b, ex_store_data, ex_branch_target;
    logic [2:0]  alu_control;
    logic [4:0]  ex_write_reg;
    logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch;
    logic        load_use_stall;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    id_ex_stage #(.DATA_W(32), .REG_AW(5)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .id_valid(id_valid),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
        .id_pc_plus4(id_pc_plus4), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_alu_src(id_alu_src), .id_reg_dst(id_reg_dst), .id_alu_control(id_alu_control),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .id_mem_write(id_mem_write), .id_branch(id_branch),
        .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd),
        .exmem_alu_result(exmem_alu_result), .memwb_reg_write(memwb_reg_write),
        .memwb_rd(memwb_rd), .memwb_wdata(memwb_wdata),
        .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control),
        .ex_store_data(ex_store_data), .ex_write_reg(ex_write_reg),
        .ex_branch_target(ex_branch_target), .ex_valid(ex_valid),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_branch(ex_branch),
        .load_use_stall(load_use_stall)
    );

    typedef struct packed {
        logic        valid, rw, mr, mw, br, src;
        logic [2:0]  ctrl;
        logic [4:0]  rs, rt, wr;
        logic [31:0] rs_d, rt_d, imm, tgt;
    } exp_t;

    exp_t cur;
    exp_t sb[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] fwd(input logic [4:0] idx, input logic [31:0] rf);
`ifdef ID_EX_FWD_EN
        if (exmem_reg_write && exmem_rd != 5'd0 && exmem_rd == idx) return exmem_alu_result;
        if (memwb_reg_write && memwb_rd != 5'd0 && memwb_rd == idx) return memwb_wdata;
`endif
        return rf;
    endfunction

    function automatic logic exp_lu(input exp_t e);
        logic prod;
`ifdef ID_EX_FWD_EN
        prod = e.mr;
`else
        prod = e.mr | e.rw;
`endif
        return e.valid & prod & (e.wr != 5'd0) & ((e.wr == id_rs) | (e.wr == id_rt));
    endfunction

    // reference next state from current inputs and the last expected state
    function automatic exp_t nxt(input exp_t c);
        exp_t n = c;
        if (flush) begin
            n.valid = 0; n.rw = 0; n.mr = 0; n.mw = 0; n.br = 0; n.src = 0; n.ctrl = 3'b000;
        end else if (!stall) begin
            n.valid = id_valid; n.rw = id_reg_write; n.mr = id_mem_read;
            n.mw = id_mem_write; n.br = id_branch; n.src = id_alu_src;
            n.ctrl = id_alu_control; n.rs = id_rs; n.rt = id_rt;
            n.wr = id_reg_dst ? id_rd : id_rt;
            n.rs_d = id_rs_data; n.rt_d = id_rt_data; n.imm = id_imm;
            n.tgt = id_pc_plus4 + {id_imm[29:0], 2'b00};
        end
        return n;
    endfunction

    task automatic check_out(input string tag);
        chk({tag, ".alu_a"},   alu_a,         fwd(cur.rs, cur.rs_d));
        chk({tag, ".alu_b"},   alu_b,         cur.src ? cur.imm : fwd(cur.rt, cur.rt_d));
        chk({tag, ".store"},   ex_store_data, fwd(cur.rt, cur.rt_d));
        chk({tag, ".ctrl"},    {29'd0, alu_control}, {29'd0, cur.ctrl});
        chk({tag, ".wr"},      {27'd0, ex_write_reg}, {27'd0, cur.wr});
        chk({tag, ".tgt"},     ex_branch_target, cur.tgt);
        chk({tag, ".valid"},   {31'd0, ex_valid},     {31'd0, cur.valid});
        chk({tag, ".rw"},      {31'd0, ex_reg_write}, {31'd0, cur.valid & cur.rw});
        chk({tag, ".mr"},      {31'd0, ex_mem_read},  {31'd0, cur.valid & cur.mr});
        chk({tag, ".mw"},      {31'd0, ex_mem_write}, {31'd0, cur.valid & cur.mw});
        chk({tag, ".br"},      {31'd0, ex_branch},    {31'd0, cur.valid & cur.br});
        chk({tag, ".lu"},      {31'd0, load_use_stall}, {31'd0, exp_lu(cur)});
    endtask

    // one clock edge: push the model's expectation, pop and compare after the edge
    task automatic step(input string tag);
        sb.push_back(nxt(cur));
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            checks++; failures++;
            $display("FAIL %s scoreboard empty observed=0 expected=1", tag);
        end else begin
            cur = sb.pop_front();
            check_out(tag);
        end
    endtask

    task automatic set_instr(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                             input logic [31:0] rsd, input logic [31:0] rtd,
                             input logic [31:0] imm, input logic src, input logic [2:0] op,
                             input logic rw, input logic mr, input logic mw, input logic br);
        id_valid = 1; id_rs = rs; id_rt = rt; id_rd = rd; id_rs_data = rsd; id_rt_data = rtd;
        id_imm = imm; id_alu_src = src; id_alu_control = op; id_reg_write = rw;
        id_mem_read = mr; id_mem_write = mw; id_branch = br; id_reg_dst = ~mr;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 0; stall = 0; flush = 0; id_valid = 0;
        id_rs_data = 0; id_rt_data = 0; id_imm = 0; id_pc_plus4 = 0;
        id_rs = 0; id_rt = 0; id_rd = 0; id_alu_src = 0; id_reg_dst = 0;
        id_alu_control = 0; id_reg_write = 0; id_mem_read = 0; id_mem_write = 0; id_branch = 0;
        exmem_reg_write = 0; exmem_rd = 0; exmem_alu_result = 0;
        memwb_reg_write = 0; memwb_rd = 0; memwb_wdata = 0;
        cur = '0;

        // reset state
        #2;
        check_out("reset");
        rst_n = 1;

        // basic latch: sub 5,3
        set_instr(5'd1, 5'd2, 5'd4, 32'd5, 32'd3, 32'd0, 1'b0, 3'b001, 1, 0, 0, 0);
        id_pc_plus4 = 32'h100;
        step("latch");
        chk("latch.a_const", alu_a, 32'd5);
        chk("latch.b_const", alu_b, 32'd3);

        // immediate operand, store data stays rt; branch control bit
        set_instr(5'd3, 5'd7, 5'd0, 32'hA5A5_0000, 32'h0000_1234, 32'h0000_0007, 1'b1, 3'b100,
                  0, 0, 1, 1);
        step("imm_sw");

        // forwarding priority on rs=8, rt=9
        set_instr(5'd8, 5'd9, 5'd10, 32'h55, 32'h66, 32'd0, 1'b0, 3'b010, 1, 0, 0, 0);
        step("fwd_load");
        exmem_reg_write = 1; exmem_rd = 5'd8; exmem_alu_result = 32'h11;
        memwb_reg_write = 1; memwb_rd = 5'd8; memwb_wdata = 32'h22;
        #1 check_out("fwd_exmem");
        exmem_reg_write = 0;
        #1 check_out("fwd_memwb");
        exmem_reg_write = 1; exmem_rd = 5'd0; memwb_rd = 5'd0;
        #1 check_out("fwd_r0");
        memwb_rd = 5'd9; memwb_wdata = 32'h99;
        #1 check_out("fwd_rt");
        exmem_reg_write = 0; exmem_rd = 0; exmem_alu_result = 0;
        memwb_reg_write = 0; memwb_rd = 0; memwb_wdata = 0;

        // load-use: lw into r9, then ID reads r9
        set_instr(5'd2, 5'd9, 5'd0, 32'h40, 32'h0, 32'h4, 1'b1, 3'b000, 1, 1, 0, 0);
        step("lw");
        id_rs = 5'd9; id_rt = 5'd3; id_mem_read = 0; id_reg_dst = 1;
        #1 check_out("lu_hit");
        chk("lu_hit.const", {31'd0, load_use_stall}, 32'd1);
        stall = 1; flush = 1;
        step("lu_bubble");
        stall = 0; flush = 0;

        // ALU producer followed by a dependent reader: interlocks only without forwarding
        set_instr(5'd1, 5'd2, 5'd6, 32'd10, 32'd20, 32'd0, 1'b0, 3'b000, 1, 0, 0, 0);
        step("alu_prod");
        id_rs = 5'd6;
        #1 check_out("raw_alu");

        // stall hold for three cycles while ID inputs change
        set_instr(5'd4, 5'd5, 5'd12, 32'h1111, 32'h2222, 32'h3, 1'b0, 3'b011, 1, 0, 0, 0);
        step("hold_load");
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            set_instr(5'(i + 13), 5'(i + 20), 5'(i + 26), $urandom, $urandom, $urandom,
                      1'($urandom), 3'($urandom_range(0, 4)), 1, 1, 1, 1);
            id_pc_plus4 = $urandom;
            step("hold");
        end
        stall = 0;

        // flush alone
        flush = 1;
        step("flush");
        flush = 0;

        // branch target wrap
        set_instr(5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'h0000_0002, 1'b1, 3'b001, 0, 0, 0, 1);
        id_pc_plus4 = 32'hFFFF_FFFC;
        step("wrap");
        chk("wrap.const", ex_branch_target, 32'h0000_0004);

        // asynchronous reset mid-operation
        set_instr(5'd1, 5'd2, 5'd3, 32'd7, 32'd9, 32'd0, 1'b0, 3'b000, 1, 0, 0, 0);
        step("pre_rst");
        #2 rst_n = 0;
        cur = '0;
        #1 check_out("async_rst");
        chk("async_rst.valid_const", {31'd0, ex_valid}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
ID/EX pipeline register with operand forwarding, directly upstream of the ALU in the 5-stage MIPS pipeline. Captures decoded operands and control each cycle. Selects forwarded ALU operands from the EX/MEM and MEM/WB stages. Detects load-use hazards and produces the branch target for the EX stage.

Parameters:
DATA_W, 32, datapath width
REG_AW, 5, register-index width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
stall  in  1  hold ID/EX contents
flush  in  1  load a bubble into ID/EX
id_valid  in  1  ID holds a real instruction
id_rs_data, id_rt_data  in  DATA_W  register-file read data
id_imm  in  DATA_W  sign-extended immediate
id_pc_plus4  in  DATA_W  PC+4 of the ID instruction
id_rs, id_rt, id_rd  in  REG_AW  register indices
id_alu_src  in  1  1 = B operand is the immediate
id_reg_dst  in  1  1 = destination is rd, 0 = rt
id_alu_control  in  3  ALU opcode (000 add, 001 sub, 010 and, 011 or, 100 slt)
id_reg_write, id_mem_read, id_mem_write, id_branch  in  1  control bits
exmem_reg_write  in  1;  exmem_rd  in  REG_AW;  exmem_alu_result  in  DATA_W
memwb_reg_write  in  1;  memwb_rd  in  REG_AW;  memwb_wdata  in  DATA_W
alu_a, alu_b  out  DATA_W  ALU operands (after forwarding)
alu_control  out  3  registered ALU opcode
ex_store_data  out  DATA_W  forwarded rt value for sw
ex_write_reg  out  REG_AW  resolved destination register
ex_branch_target  out  DATA_W  pc_plus4 + (imm << 2)
ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch  out  1
load_use_stall  out  1  request a stall of IF/ID

Behaviour:
- Reset: rst_n low asynchronously clears every register.
  - All 1-bit outputs read 0, alu_control reads 000, ex_write_reg reads 0.
  - alu_a, alu_b, ex_store_data and ex_branch_target read 0; all forward sources are inactive.
- Register update on each rising clk, priority order:
  1. flush: valid and all control bits cleared; data registers may keep stale values.
  2. stall: all registers hold.
  3. Otherwise: load all id_* values; ex_valid is set to id_valid.
  - flush and stall together: flush wins.
- Latency: one cycle from id_* inputs to registered EX values.
- ex_write_reg: registered from id_reg_dst ? id_rd : id_rt.
- Control gating: when ex_valid = 0, ex_reg_write, ex_mem_read, ex_mem_write and ex_branch must read 0.
- ex_branch_target: registered, computed as id_pc_plus4 + (id_imm << 2), modulo 2^32 (wraps, no overflow flag).
- Forwarding is combinational on registered rs/rt. Per operand X in {rs, rt}:
  - EX/MEM: if exmem_reg_write, exmem_rd != 0 and exmem_rd == X, use exmem_alu_result.
  - Else MEM/WB: if memwb_reg_write, memwb_rd != 0 and memwb_rd == X, use memwb_wdata.
  - Else use the registered register-file data.
  - EX/MEM has priority over MEM/WB.
  - Register 0 is never forwarded.
- Operand selection:
  - alu_a = forwarded rs.
  - alu_b = registered imm when alu_src = 1, else forwarded rt.
  - ex_store_data = forwarded rt, regardless of alu_src.
- load_use_stall (combinational) = ex_valid & ex_mem_read & ex_write_reg != 0 & (ex_write_reg == id_rs | ex_write_reg == id_rt).
  - The hazard unit feeds this back as stall of IF/ID and flush of ID/EX.
  - This block does not self-stall.

Optional Feature:
ID_EX_FWD_EN
- Defined: forwarding as described above.
- Undefined: no forwarding muxes; alu_a, alu_b and ex_store_data use the registered register-file data only.
  - load_use_stall then also asserts for any valid EX instruction with ex_reg_write = 1 and a matching nonzero ex_write_reg.
  - This is a full RAW interlock for one EX-stage producer; software or the NOP insertion covers MEM/WB distance.

Test Plan:
- Reset mid-operation: load a valid add, then pull rst_n low between edges -> all outputs read 0 immediately, without a clock edge.
- Basic latch: id_rs_data = 5, id_rt_data = 3, alu_src = 0, alu_control = 001, then one edge -> alu_a = 5, alu_b = 3, alu_control = 001, ex_valid = 1.
- Forward priority: registered rs = 8; exmem (we = 1, rd = 8, result = 0x11); memwb (we = 1, rd = 8, wdata = 0x22) -> alu_a = 0x11. Drop exmem_reg_write -> alu_a = 0x22. Set rd = 0 on both -> alu_a = the register-file value.
- Load-use: EX holds lw with rt = 9; ID has id_rs = 9 -> load_use_stall = 1. Apply stall = 1 and flush = 1 -> next edge gives ex_valid = 0 and all control bits 0.
- Stall hold: stall = 1 for 3 cycles while id_* inputs change -> all EX outputs unchanged.
- Branch target wrap: id_pc_plus4 = 0xFFFFFFFC, id_imm = 0x00000002 -> ex_branch_target = 0x00000004.
